// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg : shared state encoding and reset constants for pipe_stage_skid
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam logic [31:0] PIPE_RESET_PC = 32'h00003008;
  // Every bit of the NOP payload takes this value; all-zero decodes as a bubble.
  localparam logic        PIPE_NOP_BIT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot : W-bit payload plus 32-bit PC register with load and clear
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int           W        = 64,
  parameter logic [31:0]  RESET_PC = PIPE_RESET_PC,
  parameter logic [W-1:0] NOP_DATA = {W{PIPE_NOP_BIT}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  input  logic [31:0]  pc_i,
  output logic [W-1:0] data_o,
  output logic [31:0]  pc_o
);

  logic [W-1:0] data_q;
  logic [31:0]  pc_q;

  // Clear wins over load so a flush can never be overridden by a same-cycle load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= NOP_DATA;
      pc_q   <= RESET_PC;
    end else if (clear_i) begin
      data_q <= NOP_DATA;
      pc_q   <= RESET_PC;
    end else if (load_i) begin
      data_q <= data_i;
      pc_q   <= pc_i;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid : valid/ready pipeline stage register with 2-entry skid
//                   buffer; optional perf counters under PIPE_STAGE_PERF_EN
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int           W        = 64,
  parameter logic [31:0]  RESET_PC = PIPE_RESET_PC,
  parameter logic [W-1:0] NOP_DATA = {W{PIPE_NOP_BIT}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [31:0]  in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]  stall_cnt,
  output logic [31:0]  bubble_cnt,
`endif
  output logic [31:0]  out_pc
);

  state_e       state_q, state_d;
  logic         in_fire, out_fire;
  logic         main_load, main_clear, main_from_skid;
  logic         skid_load, skid_clear;
  logic [W-1:0] skid_data, main_src_data;
  logic [31:0]  skid_pc, main_src_pc;

  // Both handshake outputs decode from the state register only.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_src_data = main_from_skid ? skid_data : in_data;
  assign main_src_pc   = main_from_skid ? skid_pc   : in_pc;

  pipe_slot #(
    .W        (W),
    .RESET_PC (RESET_PC),
    .NOP_DATA (NOP_DATA)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_src_data),
    .pc_i    (main_src_pc),
    .data_o  (out_data),
    .pc_o    (out_pc)
  );

  pipe_slot #(
    .W        (W),
    .RESET_PC (RESET_PC),
    .NOP_DATA (NOP_DATA)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_data),
    .pc_i    (in_pc),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (!out_valid)              bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid : scoreboard-based self-checking bench for pipe_stage_skid
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int          W     = 64;
  localparam logic [31:0] RPC   = 32'h00003008;
  localparam logic [W-1:0] NOPD = '0;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [31:0]  in_pc, out_pc;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt, bubble_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [W+31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.W(W), .RESET_PC(RPC), .NOP_DATA(NOPD)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .out_pc    (out_pc)
  );

  // One clock: scoreboard update at negedge, return 1ns after the rising edge.
  task automatic tick();
    logic [W+31:0] exp;
    @(negedge clk);
    if (out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h data=%h, required no output", out_pc, out_data);
      end else begin
        exp = sb.pop_front();
        if ({out_data, out_pc} !== exp) begin
          miscompares++;
          $display("FAIL sb_order: got pc=%h data=%h, required pc=%h data=%h",
                   out_pc, out_data, exp[31:0], exp[W+31:32]);
        end
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back({in_data, in_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h0000_0100);
    out_ready = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_full: got %b, required 1", out_valid); end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    vectors++;
    if (out_pc !== RPC) begin miscompares++; $display("FAIL rst_out_pc: got %h, required %h", out_pc, RPC); end
    vectors++;
    if (out_data !== NOPD) begin miscompares++; $display("FAIL rst_out_data: got %h, required %h", out_data, NOPD); end
`ifdef PIPE_STAGE_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rst_counters: got %0d/%0d, required 0/0", stall_cnt, bubble_cnt);
    end
`endif
    sb.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== RPC || out_data !== NOPD) begin
        miscompares++;
        $display("FAIL idle_%0d: got v=%b r=%b pc=%h d=%h, required v=0 r=1 pc=%h d=0",
                 i, out_valid, in_ready, out_pc, out_data, RPC);
      end
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i));
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * i) || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_%0d: got v=%b pc=%h r=%b, required v=1 pc=%h r=1",
                 i, out_valid, out_pc, in_ready, 32'h3000 + 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h3000);
    tick();
    drive(1'b1, 32'h3004);
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_pc !== 32'h3000) begin
      miscompares++; $display("FAIL bp_skid: got r=%b pc=%h, required r=0 pc=00003000", in_ready, out_pc);
    end
    drive(1'b1, 32'h3abc);
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_hold: got r=%b v=%b pc=%h, required r=0 v=1 pc=00003000", in_ready, out_valid, out_pc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_pc !== 32'h3004 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_pop1: got v=%b r=%b pc=%h, required v=1 r=1 pc=00003004", out_valid, in_ready, out_pc);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== NOPD) begin
      miscompares++; $display("FAIL bp_empty: got v=%b d=%h, required v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_flush_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'h4000);
    tick();
    drive(1'b1, 32'h4004);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h4444);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== NOPD || out_pc !== RPC || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_skid: got v=%b d=%h pc=%h r=%b, required v=0 d=0 pc=%h r=1",
               out_valid, out_data, out_pc, in_ready, RPC);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak_%0d: got v=%b pc=%h, required v=0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b1;
    drive(1'b1, 32'h5000);
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++; $display("FAIL flush_fire: got v=%b pending=%0d, required v=0 pending=0", out_valid, sb.size());
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dup: got v=%b pc=%h, required v=0", out_valid, out_pc); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    logic [31:0] s0, b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h6000);
    tick();
    in_valid = 1'b0;
    s0 = stall_cnt;
    b0 = bubble_cnt;
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    repeat (3) tick();
    vectors++;
    if (stall_cnt - s0 !== 32'd5) begin miscompares++; $display("FAIL perf_stall: got %0d, required 5", stall_cnt - s0); end
    vectors++;
    if (bubble_cnt - b0 !== 32'd3) begin miscompares++; $display("FAIL perf_bubble: got %0d, required 3", bubble_cnt - b0); end
    out_ready = 1'b0;
    drive(1'b1, 32'h6004);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s0 = stall_cnt;
    b0 = bubble_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (stall_cnt !== s0 || bubble_cnt !== b0) begin
      miscompares++; $display("FAIL perf_flush: got %0d/%0d, required %0d/%0d", stall_cnt, bubble_cnt, s0, b0);
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h8000 + 32'(4 * i));
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain: got pending=%0d v=%b, required 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_pc     = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_flush_fire();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field MIPS stage registers (IF/ID, ID/EX, ...).
- Carries an opaque W-bit control/instruction payload plus a 32-bit PC tag between two pipeline stages.
- Uses a valid/ready handshake instead of a bare stall input, and adds a synchronous flush.
- A 2-entry skid buffer keeps in_ready registered, which breaks the stall combinational path across stages.

Parameters:
- W, 64, payload width in bits (IR plus decoded control bundle).
- RESET_PC, 32'h00003008, PC tag value after reset or flush.
- NOP_DATA, 0, payload value presented while empty, after reset and after flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch/exception redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry; registered.
- in_data  in  W  upstream payload.
- in_pc  in  32  upstream PC tag.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  W  main payload.
- out_pc  out  32  main PC tag.

Behaviour:
- Event definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- States:
  - EMPTY: main slot invalid.
  - FULL: main slot valid, skid slot invalid.
  - SKID: both slots valid.
- Output decode:
  - in_ready = (state != SKID), decoded from the state register only.
  - out_valid = (state != EMPTY).
- Reset (asynchronous, any time, including mid-handshake):
  - State goes to EMPTY.
  - Main and skid data go to NOP_DATA; main and skid PC go to RESET_PC.
  - Resulting outputs: out_valid=0, in_ready=1, out_data=NOP_DATA, out_pc=RESET_PC.
- Flush (synchronous, highest priority over every transition):
  - Next state is EMPTY; both slots are cleared as on reset.
  - An in_fire in the same cycle is dropped. An out_fire in the same cycle still counts as consumed by downstream.
- Transitions when not flushing:
  - EMPTY: on in_fire, main <= in, go to FULL.
  - FULL, in_fire & out_fire: main <= in, stay FULL.
  - FULL, in_fire & !out_fire: skid <= in, go to SKID.
  - FULL, !in_fire & out_fire: main <= NOP_DATA/RESET_PC, go to EMPTY.
  - FULL, neither: hold.
  - SKID: no input is accepted. On out_fire, main <= skid, skid cleared, go to FULL; otherwise hold.
- Latency:
  - 1 cycle from in_fire to out_valid when the stage was EMPTY or FULL-with-drain.
  - Throughput is 1 entry/cycle while out_ready=1.
- Ordering:
  - Strict FIFO order; no entry is duplicated or lost except by flush.
  - The payload is never modified.
- Hold rules:
  - While out_valid=1 and out_ready=0, out_data and out_pc are stable.
  - While empty, out_data = NOP_DATA so downstream decode sees a bubble.
- Upstream rules:
  - in_valid may drop without handshake (speculative fetch).
  - Data is sampled only on in_fire.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined, two output ports are added:
  - stall_cnt [31:0]: increments every cycle with out_valid & !out_ready.
  - bubble_cnt [31:0]: increments every cycle with !out_valid.
  - Both reset to 0 on reset only (not on flush) and wrap modulo 2^32.
- Without the macro, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {ST_EMPTY, ST_FULL, ST_SKID};
  - the RESET_PC default constant 32'h00003008;
  - the NOP encoding.
- One natural sub-module, pipe_slot:
  - W-bit data plus 32-bit PC register with load and clear, reset to NOP/RESET_PC.
  - Instantiated twice, as main and skid.
- The state machine stays in pipe_stage_skid.

Test Plan:
- Reset and idle: assert reset mid-cycle with in_valid=1 -> immediately out_valid=0, in_ready=1, out_pc=32'h00003008, out_data=0; held for 3 cycles after release with in_valid=0.
- Streaming: out_ready=1, feed pc 0x3000, 0x3004, 0x3008 on consecutive cycles -> out_pc shows the same sequence one cycle later with out_valid=1 each cycle; in_ready never drops.
- Backpressure into skid:
  - Setup: FULL with pc 0x3000; set out_ready=0 and present 0x3004.
  - Expected: SKID; in_ready=0 next cycle; out_pc holds 0x3000.
  - Then raise out_ready for 2 cycles: out_pc goes 0x3000 -> 0x3004, then EMPTY.
- Flush in SKID with simultaneous in_valid=1: next cycle out_valid=0, out_data=NOP_DATA, out_pc=RESET_PC, in_ready=1; the pending input is never emitted.
- Flush versus fire: flush together with out_fire in FULL -> the entry is counted as consumed once; stage EMPTY; no duplicate output on the following cycle.
- PIPE_STAGE_PERF_EN: hold out_ready=0 for 5 cycles while FULL, then 3 empty cycles -> stall_cnt=5, bubble_cnt=3; flush leaves both unchanged.
